keypad_scanner: RTL and testbench

Input-side counterpart of the multiplexed seven-segment driver. It scans a 4x4 active-low matrix keypad one column at a time and debounces per scan frame. It reports each accepted key as a 4-bit code with a one-cycle strobe, plus a held level and a release strobe. It is clocked from the 10 kHz scan clock and feeds mode, adjust and alarm-setting logic as a replacement for switch-based entry.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scanner_if.sv | 23 ++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key codes are row_idx*4 + col_idx.
package keypad_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_t;

  typedef struct packed {
    frame_res_t              res;
    logic [KEY_CODE_W-1:0]   code;
  } frame_t;

  function automatic logic [KEY_CODE_W-1:0] key_index(input logic [1:0] row,
                                                       input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]       row_n;
  logic [COLS-1:0]       col_n;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_held;
  logic                  key_release;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_held, key_release
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_held, key_release
  );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up inputs).
// Latency 2 cycles; no backpressure.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad decoder with per-frame debounce and rollover lock.
// Strobes appear one cycle after the deciding frame-end sample; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 10,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       clock,
  input  logic       rst,
  keypad_scanner_if.master kp
);

  localparam int             DW    = $clog2(SCAN_DIV);
  localparam logic [3:0]     DEB_N = 4'(DEBOUNCE_FRAMES);

  logic [ROWS-1:0] row_sync;
  logic [ROWS-1:0] pressed;

  keypad_sync #(.WIDTH(ROWS)) u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (kp.row_n),
    .q     (row_sync)
  );

  assign pressed = ~row_sync;

  // Scan sequencer
  logic [DW-1:0] dwell;
  logic [1:0]    col_sel;
  logic          sample;
  logic          frame_end;

  assign sample    = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_sel == 2'd3);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      dwell   <= '0;
      col_sel <= 2'd0;
    end else if (sample) begin
      dwell   <= '0;
      col_sel <= col_sel + 2'd1;
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  assign kp.col_n = ~(COLS'(1) << col_sel);

  // Frame accumulator; the merged view folds in the current column's sample
  logic [1:0]            acc_cnt;
  logic [KEY_CODE_W-1:0] acc_code;
  logic [1:0]            mrg_cnt;
  logic [KEY_CODE_W-1:0] mrg_code;
  frame_t                frame;

  always_comb begin
    mrg_cnt  = acc_cnt;
    mrg_code = acc_code;
    for (int r = 0; r < ROWS; r++) begin
      if (pressed[r]) begin
        if (mrg_cnt != 2'd2) mrg_cnt = mrg_cnt + 2'd1;
        mrg_code = key_index(2'(r), col_sel);
      end
    end
  end

  always_comb begin
    frame.code = mrg_code;
    case (mrg_cnt)
      2'd0:    frame.res = NONE;
      2'd1:    frame.res = SINGLE;
      default: frame.res = MULTI;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= '0;
    end else if (frame_end) begin
      acc_cnt  <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      acc_cnt  <= mrg_cnt;
      acc_code <= mrg_code;
    end
  end

  // Debounce FSM, advanced once per frame result
  state_t                state;
  logic [3:0]            cnt;
  logic [KEY_CODE_W-1:0] cand;
  logic [KEY_CODE_W-1:0] code_r;
  logic                  valid_r;
  logic                  held_r;
  logic                  release_r;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= '0;
      code_r    <= '0;
      valid_r   <= 1'b0;
      held_r    <= 1'b0;
      release_r <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      release_r <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame.res == SINGLE) begin
              cand <= frame.code;
              if (DEB_N == 4'd1) begin
                state   <= PRESSED;
                cnt     <= 4'd0;
                code_r  <= frame.code;
                valid_r <= 1'b1;
                held_r  <= 1'b1;
              end else begin
                state <= DEB_PRESS;
                cnt   <= 4'd1;
              end
            end
          end
          DEB_PRESS: begin
            if (frame.res == SINGLE && frame.code == cand) begin
              if (cnt + 4'd1 == DEB_N) begin
                state   <= PRESSED;
                cnt     <= 4'd0;
                code_r  <= cand;
                valid_r <= 1'b1;
                held_r  <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end
          PRESSED: begin
            // Other keys while held are ignored until a full release
            if (frame.res == NONE) begin
              if (DEB_N == 4'd1) begin
                state     <= IDLE;
                cnt       <= 4'd0;
                held_r    <= 1'b0;
                release_r <= 1'b1;
              end else begin
                state <= DEB_RELEASE;
                cnt   <= 4'd1;
              end
            end
          end
          DEB_RELEASE: begin
            if (frame.res == NONE) begin
              if (cnt + 4'd1 == DEB_N) begin
                state     <= IDLE;
                cnt       <= 4'd0;
                held_r    <= 1'b0;
                release_r <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= PRESSED;
              cnt   <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign kp.key_code    = code_r;
  assign kp.key_valid   = valid_r;
  assign kp.key_held    = held_r;
  assign kp.key_release = release_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized + scenario bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=3).
// A frame-level reference model predicts strobes, code and held level every cycle.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int FRAME = 4 * SD;

  logic        clock;
  logic        rst;
  logic [15:0] keys;
  int          n_cmp;
  int          n_bad;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DEB)) dut (
    .clock (clock),
    .rst   (rst),
    .kp    (kif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical keypad: a closed key pulls its row low while its column is driven
  always_comb begin
    kif.row_n = '1;
    for (int r = 0; r < 4; r++)
      kif.row_n[r] = ~|(keys[r*4 +: 4] & ~kif.col_n);
  end

  // Reference model state (frame-level)
  bit         m_held;
  logic [3:0] m_code;
  logic [3:0] m_cand;
  int         m_streak;
  bit         pend_valid;
  bit         pend_release;
  bit         shown_held;
  logic [3:0] shown_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_held       = 0;
    m_code       = 4'd0;
    m_cand       = 4'd0;
    m_streak     = 0;
    pend_valid   = 0;
    pend_release = 0;
    shown_held   = 0;
    shown_code   = 4'd0;
  endtask

  // A press is accepted after DEB consecutive frames showing the same single key;
  // a release after DEB consecutive empty frames. A frame with a different single
  // key while a press is building is lost (the new key starts counting next frame).
  task automatic model_step(input logic [15:0] k);
    int         n;
    logic [3:0] c;
    n = $countones(k);
    c = 4'd0;
    for (int i = 0; i < 16; i++) if (k[i]) c = 4'(i);
    pend_valid   = 0;
    pend_release = 0;
    if (!m_held) begin
      if (n == 1 && (m_streak == 0 || c == m_cand)) begin
        m_cand   = c;
        m_streak = m_streak + 1;
        if (m_streak == DEB) begin
          pend_valid = 1;
          m_held     = 1;
          m_code     = c;
          m_streak   = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (n == 0) begin
        m_streak = m_streak + 1;
        if (m_streak == DEB) begin
          pend_release = 1;
          m_held       = 0;
          m_streak     = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // Runs ncyc cycles of a frame starting at its first cycle (called at a negedge)
  task automatic run_frame(input logic [15:0] k, input int ncyc);
    logic [3:0] exp_col;
    logic [3:0] one;
    for (int i = 0; i < ncyc; i++) begin
      one     = 4'b0001;
      exp_col = ~(one << (i / SD));
      chk("col_n", kif.col_n, exp_col);
      if (i == 0) begin
        chk("key_valid", kif.key_valid, pend_valid);
        chk("key_release", kif.key_release, pend_release);
        shown_held = m_held;
        shown_code = m_code;
        keys = k;
        model_step(k);
      end else begin
        chk("key_valid_idle", kif.key_valid, 1'b0);
        chk("key_release_idle", kif.key_release, 1'b0);
      end
      chk("key_held", kif.key_held, shown_held);
      chk("key_code", kif.key_code, shown_code);
      @(negedge clock);
    end
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    repeat (n) run_frame(k, FRAME);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_col_n", kif.col_n, 4'b1110);
    chk("rst_key_code", kif.key_code, 4'd0);
    chk("rst_key_valid", kif.key_valid, 1'b0);
    chk("rst_key_held", kif.key_held, 1'b0);
    chk("rst_key_release", kif.key_release, 1'b0);
    keys = 16'h0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_hold_valid", kif.key_valid, 1'b0);
      chk("rst_hold_release", kif.key_release, 1'b0);
      chk("rst_hold_held", kif.key_held, 1'b0);
    end
    @(negedge clock);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] k;
    int          sel;
    int          a;
    int          b;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    keys  = 16'h0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Idle scan
    frames(16'h0, 13);
    // Clean press of key 9, then release
    frames(16'h1 << 9, 6);
    frames(16'h0, 5);
    // Bounce on key 3
    frames(16'h1 << 3, 2);
    frames(16'h0, 1);
    frames(16'h1 << 3, 4);
    frames(16'h0, 4);
    // Rollover: 5, then 5+6, then 6 alone, then release
    frames(16'h1 << 5, 4);
    frames((16'h1 << 5) | (16'h1 << 6), 2);
    frames(16'h1 << 6, 3);
    frames(16'h0, 4);
    // Two keys from idle
    frames((16'h1 << 0) | (16'h1 << 15), 10);
    frames(16'h0, 2);
    // Code switch mid-debounce, then DEBOUNCE boundary (exactly DEB frames)
    frames(16'h1 << 10, 2);
    frames(16'h1 << 12, 3);
    frames(16'h0, 3);
    frames(16'h1 << 14, 2);
    frames(16'h0, 2);

    // Reset during press debounce (two qualifying frames seen)
    frames(16'h1 << 7, 2);
    run_frame(16'h1 << 7, FRAME / 2);
    do_reset();
    frames(16'h0, 2);
    // Reset while pressed
    frames(16'h1 << 11, 4);
    run_frame(16'h1 << 11, FRAME / 2);
    do_reset();
    frames(16'h0, 3);

    // Randomized bursts
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 3);
      a   = $urandom_range(0, 15);
      b   = (a + $urandom_range(1, 15)) % 16;
      case (sel)
        0:       k = 16'h0;
        1, 2:    k = 16'h1 << a;
        default: k = (16'h1 << a) | (16'h1 << b);
      endcase
      frames(k, $urandom_range(1, 5));
    end
    frames(16'h0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
